coffee_brew_ctrl: RTL and testbench

Clocked brew sequencer for the coffee machine. It samples the four machine status flags (filter, water, temperature, cup, on the same F/W/T/C lines the combinational coffee machine decodes) and runs a user brew request through check, heat, brew and done phases. It drives the heater and pump, enforces a heat-up timeout, and aborts to a latched fault on loss of preconditions. It sits between the front-panel inputs and the actuator drivers; all flag inputs are already synchronous to `clk`.

---
 rtl/coffee_brew_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_coffee_brew_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/coffee_brew_ctrl.sv
// coffee_brew_ctrl: clocked brew sequencer for the coffee machine.
// Walks a brew request through CHECK -> HEAT -> BREW -> DONE. It drives the
// heater and pump, gives up on a heat-up timeout, and drops into a latched
// FAULT when water or cup goes missing. Every output comes from a register
// that is loaded from the next-state decode, so each output changes on the
// same edge that enters the state it belongs to.
module coffee_brew_ctrl #(
    parameter int HEAT_TIMEOUT = 16,
    parameter int BREW_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cancel,
    input  logic       clear,
    input  logic       F,
    input  logic       W,
    input  logic       T,
    input  logic       C,
    output logic       heat,
    output logic       pump,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state
);

    // One shared counter serves both the heat timeout and the pump-cycle
    // count, so it is sized for whichever limit is larger.
    localparam int MAX_LIMIT = (HEAT_TIMEOUT > BREW_CYCLES) ? HEAT_TIMEOUT : BREW_CYCLES;
    localparam int CNT_W     = $clog2(MAX_LIMIT + 1);

    localparam logic [CNT_W-1:0] HEAT_LAST = CNT_W'(HEAT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BREW_LAST = CNT_W'(BREW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_PRECOND = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_HEAT  = 3'd2,
        ST_BREW  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;

    logic heat_q, heat_d;
    logic pump_q, pump_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic fault_q, fault_d;

    // Next-state, counter and fault-code decode. In CHECK, HEAT and BREW a
    // cancel wins over a lost precondition, and a lost precondition wins
    // over normal progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end
            end

            ST_CHECK: begin
                // T is left to the HEAT phase; only filter, water and cup gate the brew.
                if (cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (F && W && C) begin
                    state_d = ST_HEAT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                    code_d  = CODE_PRECOND;
                end
            end

            ST_HEAT: begin
                // Losing the filter mid-brew is harmless, so F is not looked at from here on.
                if (cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!W || !C) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                    code_d  = CODE_PRECOND;
                end else if (T) begin
                    state_d = ST_BREW;
                    cnt_d   = '0;
                end else if (cnt_q == HEAT_LAST) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                    code_d  = CODE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_BREW: begin
                // A temperature dropout just pauses the pump; the count holds until T returns.
                if (cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!W || !C) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                    code_d  = CODE_PRECOND;
                end else if (T) begin
                    if (cnt_q == BREW_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            ST_FAULT: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    code_d  = CODE_NONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                code_d  = CODE_NONE;
            end
        endcase
    end

    // Output decode from the state being entered, so every output register
    // changes on the same edge as the state register.
    always_comb begin
        heat_d  = (state_d == ST_HEAT) || (state_d == ST_BREW);
        pump_d  = (state_d == ST_BREW) && T;
        busy_d  = (state_d == ST_CHECK) || (state_d == ST_HEAT) ||
                  (state_d == ST_BREW)  || (state_d == ST_DONE);
        done_d  = (state_d == ST_DONE);
        fault_d = (state_d == ST_FAULT);
    end

    // State, counter and output registers; reset forces everything idle
    // and the actuators off without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= CODE_NONE;
            heat_q  <= 1'b0;
            pump_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            heat_q  <= heat_d;
            pump_q  <= pump_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign heat       = heat_q;
    assign pump       = pump_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign state      = state_q;

endmodule

// File: tb/tb_coffee_brew_ctrl.sv
// tb_coffee_brew_ctrl: directed vector table plus hand-written multi-cycle
// sequences for the brew sequencer at its default parameters (16 / 8).
module tb_coffee_brew_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, cancel = 1'b0, clear = 1'b0;
    logic       F = 1'b0, W = 1'b0, T = 1'b0, C = 1'b0;
    logic       heat, pump, busy, done, fault;
    logic [1:0] fault_code;
    logic [2:0] state;

    int total_count = 0;
    int pass_count  = 0;

    // Input bits are {start, cancel, clear, F, W, T, C};
    // output bits are {heat, pump, busy, done, fault}.
    typedef struct {
        string      name;
        logic [6:0] ins;
        logic [4:0] outs;
        logic [1:0] code;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[$];

    coffee_brew_ctrl #(.HEAT_TIMEOUT(16), .BREW_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel), .clear(clear),
        .F(F), .W(W), .T(T), .C(C),
        .heat(heat), .pump(pump), .busy(busy), .done(done), .fault(fault),
        .fault_code(fault_code), .state(state)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input string name, input logic [6:0] ins, input logic [4:0] outs,
                          input logic [1:0] code, input logic [2:0] st);
        vec_t v;
        v.name = name; v.ins = ins; v.outs = outs; v.code = code; v.st = st;
        vecs.push_back(v);
    endtask

    // Drive inputs at the falling edge, then move to just after the next rising edge.
    task automatic applyStimulus(input logic [6:0] ins);
        @(negedge clk);
        {start, cancel, clear, F, W, T, C} = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        total_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        else
            pass_count++;
    endtask

    task automatic checkAll(input string name, input logic [4:0] outs, input logic [1:0] code,
                            input logic [2:0] st);
        checkOutput({name, ".heat"},  {3'b0, heat},  {3'b0, outs[4]});
        checkOutput({name, ".pump"},  {3'b0, pump},  {3'b0, outs[3]});
        checkOutput({name, ".busy"},  {3'b0, busy},  {3'b0, outs[2]});
        checkOutput({name, ".done"},  {3'b0, done},  {3'b0, outs[1]});
        checkOutput({name, ".fault"}, {3'b0, fault}, {3'b0, outs[0]});
        checkOutput({name, ".code"},  {2'b0, fault_code}, {2'b0, code});
        checkOutput({name, ".state"}, {1'b0, state}, {1'b0, st});
    endtask

    initial begin
        int pump_high, pump_low, done_edge, done_count, heat_cycles, fault_edge;

        // ---------------- vector table ----------------
        addVec("idle_cancel", 7'b0101111, 5'b00000, 2'b00, 3'd0);
        addVec("idle_clear",  7'b0011111, 5'b00000, 2'b00, 3'd0);
        addVec("nom_e0",      7'b1001111, 5'b00100, 2'b00, 3'd1);
        addVec("nom_e1",      7'b0001111, 5'b10100, 2'b00, 3'd2);
        addVec("nom_e2",      7'b0001111, 5'b11100, 2'b00, 3'd3);
        for (int i = 3; i <= 9; i++)
            addVec($sformatf("nom_e%0d", i), 7'b0001111, 5'b11100, 2'b00, 3'd3);
        addVec("nom_e10",     7'b0001111, 5'b00110, 2'b00, 3'd4);
        addVec("nom_e11",     7'b0001111, 5'b00000, 2'b00, 3'd0);
        addVec("cup_e0",      7'b1001110, 5'b00100, 2'b00, 3'd1);
        addVec("cup_e1",      7'b0001110, 5'b00001, 2'b01, 3'd5);
        addVec("cup_start",   7'b1001110, 5'b00001, 2'b01, 3'd5);
        addVec("cup_clear",   7'b0011110, 5'b00000, 2'b00, 3'd0);
        addVec("cchk_e0",     7'b1001110, 5'b00100, 2'b00, 3'd1);
        addVec("cchk_cancel", 7'b0101110, 5'b00000, 2'b00, 3'd0);
        addVec("chot_e0",     7'b1001101, 5'b00100, 2'b00, 3'd1);
        addVec("chot_e1",     7'b0001101, 5'b10100, 2'b00, 3'd2);
        addVec("chot_e2",     7'b0001101, 5'b10100, 2'b00, 3'd2);
        addVec("chot_cancel", 7'b0101101, 5'b00000, 2'b00, 3'd0);
        addVec("nof_e0",      7'b1000111, 5'b00100, 2'b00, 3'd1);
        addVec("nof_e1",      7'b0000111, 5'b00001, 2'b01, 3'd5);
        addVec("nof_clear",   7'b0010111, 5'b00000, 2'b00, 3'd0);
        addVec("fl_e0",       7'b1001101, 5'b00100, 2'b00, 3'd1);
        addVec("fl_e1",       7'b0001101, 5'b10100, 2'b00, 3'd2);
        addVec("fl_nofilter", 7'b0000101, 5'b10100, 2'b00, 3'd2);
        addVec("fl_brew",     7'b0000111, 5'b11100, 2'b00, 3'd3);
        addVec("fl_cancel",   7'b0100111, 5'b00000, 2'b00, 3'd0);

        // ---------------- reset ----------------
        #1;
        checkAll("reset", 5'b00000, 2'b00, 3'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ins);
            checkAll(vecs[i].name, vecs[i].outs, vecs[i].code, vecs[i].st);
        end

        // ---------------- heat timeout ----------------
        applyStimulus(7'b1001101);
        heat_cycles = 0;
        fault_edge  = -1;
        for (int e = 1; e <= 20; e++) begin
            applyStimulus(7'b0001101);
            if (heat) heat_cycles++;
            if (state == 3'd5) begin
                fault_edge = e;
                break;
            end
        end
        checkOutput("timeout.heat_cycles", 4'(heat_cycles), 4'(16));
        checkOutput("timeout.edge", 4'(fault_edge), 4'(17 - 16));
        checkOutput("timeout.edge_hi", 4'(fault_edge >> 4), 4'(17 >> 4));
        checkAll("timeout.fault", 5'b00001, 2'b10, 3'd5);
        applyStimulus(7'b0011101);
        checkAll("timeout.clear", 5'b00000, 2'b00, 3'd0);

        // ---------------- temperature dropout ----------------
        applyStimulus(7'b1001111);
        applyStimulus(7'b0001111);
        pump_high  = 0;
        pump_low   = 0;
        done_edge  = -1;
        done_count = 0;
        for (int e = 2; e <= 40; e++) begin
            applyStimulus((e >= 6 && e <= 8) ? 7'b0001101 : 7'b0001111);
            if (pump) pump_high++;
            if (state == 3'd3 && !pump) pump_low++;
            if (done) begin
                done_count++;
                done_edge = e;
                break;
            end
        end
        checkOutput("dropout.pump_high", 4'(pump_high), 4'(8));
        checkOutput("dropout.pump_low", 4'(pump_low), 4'(3));
        checkOutput("dropout.done_edge", 4'(done_edge), 4'(13));
        checkOutput("dropout.done_count", 4'(done_count), 4'(1));
        // start and cancel while in DONE are ignored; a held start then restarts.
        applyStimulus(7'b1101111);
        checkAll("done_ignore", 5'b00000, 2'b00, 3'd0);
        applyStimulus(7'b1001111);
        checkAll("held_start", 5'b00100, 2'b00, 3'd1);
        applyStimulus(7'b0101111);
        checkAll("held_cancel", 5'b00000, 2'b00, 3'd0);

        // ---------------- water lost in BREW ----------------
        applyStimulus(7'b1001111);
        applyStimulus(7'b0001111);
        pump_high = 0;
        for (int e = 2; e <= 5; e++) begin
            applyStimulus(7'b0001111);
            if (pump) pump_high++;
        end
        checkOutput("water.pump_before", 4'(pump_high), 4'(4));
        applyStimulus(7'b0001011);
        checkAll("water.fault", 5'b00001, 2'b01, 3'd5);
        applyStimulus(7'b0011111);
        checkAll("water.clear", 5'b00000, 2'b00, 3'd0);

        // ---------------- async reset mid-BREW ----------------
        applyStimulus(7'b1001111);
        applyStimulus(7'b0001111);
        applyStimulus(7'b0001111);
        applyStimulus(7'b0001111);
        checkAll("arst.pre", 5'b11100, 2'b00, 3'd3);
        #2;
        rst = 1'b1;
        #1;
        checkAll("arst.now", 5'b00000, 2'b00, 3'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(7'b1001111);
        checkAll("arst.e0", 5'b00100, 2'b00, 3'd1);
        pump_high  = 0;
        done_edge  = -1;
        for (int e = 1; e <= 30; e++) begin
            applyStimulus(7'b0001111);
            if (pump) pump_high++;
            if (done) begin
                done_edge = e;
                break;
            end
        end
        checkOutput("arst.pump_high", 4'(pump_high), 4'(8));
        checkOutput("arst.done_edge", 4'(done_edge), 4'(10));
        applyStimulus(7'b0001111);
        checkAll("arst.e11", 5'b00000, 2'b00, 3'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
